conv_seq_ctrl: RTL
==================

Name: conv_seq_ctrl

Overview:
Sequencer for the multi-core 3x3 convolution datapath.
- Owns the single byte input stream: loads the 18 weight bytes for the core bank, then streams feature bytes into the shared data window.
- Schedules the per-row weight rotation, the output select between cores, and the layer-2 buffered drain.
- Only emits enable/select strobes. The datapath registers (data window, weight bank, output buffers) are driven by these strobes.

Parameters:
CHIP_NUM, 2, number of parallel CORE instances
WEIGHT_NUM, 9, weight bytes per core
SIZE_L0, 26, row length / rows for layer_num 0 (and 3)
SIZE_L1, 12, row length / rows for layer_num 1
SIZE_L2, 5, row length / rows for layer_num 2
STORE_LEN, 14, buffered outputs per core drained in layer 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  begin a layer run; sampled only in IDLE
layer_num  in  2  layer select, latched on accepted start
in_valid  in  1  byte present on i_data stream this cycle
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse at end of run
wt_shift_en  out  1  shift i_data into weight bank
data_shift_en  out  1  shift i_data into data window
wt_rotate  out  1  rotate weight bank (end of row)
core_sel  out  1  core output mux select (layers 0/1)
out_valid  out  1  o_data valid this cycle
store_en  out  1  capture core outputs into output buffers (layer 2)
drain_en  out  1  shift selected output buffer toward o_data
drain_chip  out  1  output buffer being drained
col_cnt  out  5  current column, 1..size

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0, FSM in IDLE. Counters cleared: wcnt, col_cnt, dcnt, drcnt.
- Latched layer_num sets size: 0 or 3 -> SIZE_L0; 1 -> SIZE_L1; 2 -> SIZE_L2.
- FRAME = size*size accepted data bytes. dcnt is 10 bits.

Timing class of each output:
- Combinational from state and in_valid: wt_shift_en, data_shift_en, wt_rotate.
- Registered: out_valid, store_en, core_sel, drain_en, drain_chip, done, busy, col_cnt.

States:
- IDLE:
  - start=1 latches layer_num, clears all counters and core_sel, then goes to LOAD_W.
  - start while busy (any other state) is ignored.
- LOAD_W:
  - wt_shift_en = in_valid; wcnt++ on each accept.
  - On accept with wcnt = CHIP_NUM*WEIGHT_NUM-1 (17), go to STREAM.
  - in_valid=0 stalls; nothing changes.
- STREAM:
  - data_shift_en = in_valid.
  - Each accept: col_cnt steps 1..size, then wraps to 1. dcnt++.
  - wt_rotate = in_valid && col_cnt == size.
  - An accept with dcnt >= CHIP_NUM+1 (window full) schedules a result on the next cycle:
    - layers 0/1: out_valid=1, then core_sel toggles.
    - layer 2: store_en=1 instead.
  - The accept with dcnt = FRAME-1 goes to FLUSH.
- FLUSH: 1 cycle. Carries the last out_valid/store_en. Layer 2 -> DRAIN; else -> DONE.
- DRAIN (layer 2 only):
  - 2*STORE_LEN cycles with drain_en=1 and out_valid=1.
  - drain_chip=0 for the first STORE_LEN cycles, 1 for the rest.
  - Then go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.

Boundaries and special cases:
- in_valid is ignored in IDLE, FLUSH, DRAIN and DONE.
- Stall in STREAM freezes col_cnt, dcnt and core_sel. No out_valid/store_en is generated for stalled cycles.
- Wrap and rotate happen in the same cycle. No rotate during LOAD_W.
- rst_n low mid-run returns to IDLE immediately; no done pulse.
- Back-to-back runs: a start accepted in the cycle after DONE works normally.

Test Plan:
- layer_num=1, start, in_valid continuous:
  - wt_shift_en for 18 cycles, then 144 data_shift_en.
  - wt_rotate 12 times, at col_cnt=12.
  - 141 out_valid pulses, core_sel alternating from 0.
  - done 2 cycles after the last byte.
- layer_num=2:
  - 25 data bytes -> 22 store_en, no out_valid during STREAM.
  - Then 28 drain cycles: drain_chip 0 for cycles 1-14, 1 for 15-28.
  - Then done.
- layer_num=1, in_valid toggled 1,0,1,0:
  - Counts identical to the continuous case.
  - No strobes on stalled cycles; col_cnt holds.
- layer_num=3:
  - Runs with size 26: 676 data bytes, 673 out_valid, 26 wt_rotate.
- start pulsed during STREAM is ignored.
- rst_n asserted at dcnt=50:
  - All outputs 0 asynchronously; no done.
  - A new start then reloads 18 weights.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl -- sequencer for the multi-core 3x3 convolution datapath.
//
// Owns the single byte input stream. It first loads CHIP_NUM*WEIGHT_NUM
// weight bytes into the core bank, then streams size*size feature bytes into
// the shared data window. It also schedules the end-of-row weight rotation,
// the output mux select between cores, and the layer-2 buffered drain. It
// produces only enable/select strobes; the datapath registers act on them.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         begin a layer run (sampled only in IDLE)
//   layer_num     layer select, latched on an accepted start
//   in_valid      byte present on the input stream this cycle
//   busy          high from the cycle after an accepted start through DONE
//   done          one-cycle pulse at the end of a run
//   wt_shift_en   shift the input byte into the weight bank   (combinational)
//   data_shift_en shift the input byte into the data window   (combinational)
//   wt_rotate     rotate the weight bank at end of row        (combinational)
//   core_sel      core output mux select (layers 0/1)
//   out_valid     output byte valid this cycle
//   store_en      capture core outputs into output buffers (layer 2)
//   drain_en      shift the selected output buffer toward the output
//   drain_chip    index of the output buffer being drained
//   col_cnt       current column, 1..size while streaming
`timescale 1ns/1ps

module conv_seq_ctrl #(
  parameter int CHIP_NUM   = 2,
  parameter int WEIGHT_NUM = 9,
  parameter int SIZE_L0    = 26,
  parameter int SIZE_L1    = 12,
  parameter int SIZE_L2    = 5,
  parameter int STORE_LEN  = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] layer_num,
  input  logic       in_valid,
  output logic       busy,
  output logic       done,
  output logic       wt_shift_en,
  output logic       data_shift_en,
  output logic       wt_rotate,
  output logic       core_sel,
  output logic       out_valid,
  output logic       store_en,
  output logic       drain_en,
  output logic       drain_chip,
  output logic [4:0] col_cnt
);

  localparam int NUM_W     = CHIP_NUM * WEIGHT_NUM;
  localparam int WIN_FULL  = CHIP_NUM + 1;
  localparam int DRAIN_LEN = 2 * STORE_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] layer_q, layer_d;
  logic [4:0] wcnt_q, wcnt_d;
  logic [4:0] col_q, col_d;
  logic [9:0] dcnt_q, dcnt_d;
  logic [4:0] drcnt_q, drcnt_d;

  logic core_sel_q, core_sel_d;
  logic out_valid_q, out_valid_d;
  logic store_en_q, store_en_d;
  logic drain_en_q, drain_en_d;
  logic drain_chip_q, drain_chip_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic [4:0] size;
  logic [9:0] frame;
  logic       is_l2;
  logic       d_acc;
  logic       result;

  // Layer 3 reuses the layer-0 geometry.
  always_comb begin
    case (layer_q)
      2'd1:    size = 5'(SIZE_L1);
      2'd2:    size = 5'(SIZE_L2);
      default: size = 5'(SIZE_L0);
    endcase
  end

  assign frame = 10'(size) * 10'(size);
  assign is_l2 = (layer_q == 2'd2);
  assign d_acc = (state_q == S_STREAM) && in_valid;
  // Once CHIP_NUM+1 bytes sit in the window every further byte yields a result.
  assign result = d_acc && (dcnt_q >= 10'(WIN_FULL));

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_q      <= 2'd0;
      wcnt_q       <= 5'd0;
      col_q        <= 5'd0;
      dcnt_q       <= 10'd0;
      drcnt_q      <= 5'd0;
      core_sel_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      store_en_q   <= 1'b0;
      drain_en_q   <= 1'b0;
      drain_chip_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      wcnt_q       <= wcnt_d;
      col_q        <= col_d;
      dcnt_q       <= dcnt_d;
      drcnt_q      <= drcnt_d;
      core_sel_q   <= core_sel_d;
      out_valid_q  <= out_valid_d;
      store_en_q   <= store_en_d;
      drain_en_q   <= drain_en_d;
      drain_chip_q <= drain_chip_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    wcnt_d  = wcnt_q;
    col_d   = col_q;
    dcnt_d  = dcnt_q;
    drcnt_d = drcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          layer_d = layer_num;
          wcnt_d  = 5'd0;
          col_d   = 5'd0;
          dcnt_d  = 10'd0;
          drcnt_d = 5'd0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (in_valid) begin
          wcnt_d = wcnt_q + 5'd1;
          if (wcnt_q == 5'(NUM_W - 1)) begin
            state_d = S_STREAM;
            // col_cnt names the column of the byte about to be accepted.
            col_d   = 5'd1;
          end
        end
      end
      S_STREAM: begin
        if (in_valid) begin
          dcnt_d = dcnt_q + 10'd1;
          col_d  = (col_q == size) ? 5'd1 : col_q + 5'd1;
          if (dcnt_q == frame - 10'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = is_l2 ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        drcnt_d = drcnt_q + 5'd1;
        if (drcnt_q == 5'(DRAIN_LEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: stream strobes are immediate, the rest are registered.
  always_comb begin
    wt_shift_en   = (state_q == S_LOAD_W) && in_valid;
    data_shift_en = d_acc;
    wt_rotate     = d_acc && (col_q == size);

    out_valid_d  = (result && !is_l2) || (state_d == S_DRAIN);
    store_en_d   = result && is_l2;
    drain_en_d   = (state_d == S_DRAIN);
    drain_chip_d = (state_d == S_DRAIN) && (drcnt_d >= 5'(STORE_LEN));
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);

    // The mux moves to the other core once the current result has gone out.
    core_sel_d = core_sel_q;
    if ((state_q == S_IDLE) && start) begin
      core_sel_d = 1'b0;
    end else if (out_valid_q && !is_l2) begin
      core_sel_d = ~core_sel_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign core_sel   = core_sel_q;
  assign out_valid  = out_valid_q;
  assign store_en   = store_en_q;
  assign drain_en   = drain_en_q;
  assign drain_chip = drain_chip_q;
  assign col_cnt    = col_q;

endmodule
